tri_raster_walk: RTL and testbench
==================================

// Module: tri_raster_walk
// PURPOSE
// Consumes the edge-equation coefficients and bounding box produced by triangle setup. It walks the
// screen-clipped box in row-major order, one candidate pixel per cycle, using incremental edge
// evaluation. It emits every covered pixel on a valid/ready stream to the fragment/framebuffer stage.
// PARAMETERS
// X_MAX  319  last visible column; bbox x is clamped to [0,X_MAX]
// Y_MAX  239  last visible row; bbox y is clamped to [0,Y_MAX]
// EW     21   signed edge accumulator width (|A*x|+|B*y|+|C| < 2^20)
// PORTS
// clk        in   1   clock, rising edge
// rst_n      in   1   reset, asynchronous, active-low
// edge_done  in   1   one-cycle pulse: coefficients/bbox below are valid this cycle
// a1,a2,a3   in   10  signed edge A coefficients (x step)
// b1,b2,b3   in   10  signed edge B coefficients (y step)
// c1,c2,c3   in   18  signed edge C constants
// bbxi,bbxf  in   9   bbox x first/last, unsigned
// bbyi,bbyf  in   8   bbox y first/last, unsigned
// rast_ready out  1   1 in IDLE: a new edge_done is accepted
// pix_valid  out  1   pix_x/pix_y hold a covered pixel
// pix_ready  in   1   downstream accepts pixel when pix_valid&&pix_ready
// pix_x      out  9   pixel column
// pix_y      out  8   pixel row
// rast_done  out  1   one-cycle pulse: triangle finished, last pixel accepted
// overrun    out  1   sticky: edge_done arrived while not IDLE (cleared only by reset)
// BEHAVIOUR
// - Reset: state=IDLE. rast_ready=1. pix_valid=0, pix_x=0, pix_y=0, rast_done=0, overrun=0.
// - Reset is honoured mid-walk: the pending pixel is dropped and no rast_done is issued.
// - IDLE: on edge_done, register all coefficients. Clip: xs=bbxi, xe=min(bbxf,X_MAX),
//   ys=bbyi, ye=min(bbyf,Y_MAX). If xs>xe or ys>ye -> go to DONE (no pixels); else -> SETUP.
// - SETUP (1 cycle): Ek = Ak*xs + Bk*ys + Ck, sign-extended to EW, for k=1..3.
//   Copy to the row-start registers Rk. Set (x,y)=(xs,ys). -> WALK.
// - WALK: each cycle where the output slot is free or being drained (!pix_valid || pix_ready):
//   * inside = E1>=0 && E2>=0 && E3>=0 (zero counts as inside); if inside, load pix_x/pix_y=(x,y),
//     pix_valid=1; else leave the slot empty.
//   * if x<xe: x+=1, Ek+=Ak. Else if y<ye: x=xs, y+=1, Rk+=Bk, Ek=Rk+Bk. Else -> DRAIN.
//   * If the slot is full and pix_ready=0: hold all state, pix_x/pix_y/pix_valid stable.
// - DRAIN: wait until !pix_valid (or pix_valid&&pix_ready this cycle) -> DONE.
// - DONE: rast_done=1 for exactly one cycle -> IDLE.
// - Latency: edge_done at cycle T -> SETUP at T+1 -> first evaluation at T+2 -> earliest pix_valid
//   at T+3. Throughput is 1 candidate/cycle with pix_ready held high.
// - pix_valid falls the cycle after acceptance unless a new covered pixel is loaded in that same
//   cycle.
// - rast_ready=1 only in IDLE. edge_done outside IDLE is ignored (latched state unchanged) and
//   sets overrun.
// - Width: all edge arithmetic is signed EW bits; x/y counters are unsigned. No wrap is possible
//   because ranges are clipped before walking.
// TESTING
// - T1: v=(0,0),(4,0),(0,4): a=(0,-4,4), b=(4,-4,0), c=(0,16,0), bbox 0..4 x 0..4, pix_ready=1
//   -> exactly 15 pixels (x+y<=4), first (0,0), last (0,4), rast_done once.
// - T2: T1 with pix_ready toggled 1-of-3 cycles -> the same 15 pixels in the same order.
//   Outputs stay stable while stalled.
// - T3: all a,b,c=0, bbox x=400..420 -> xs>X_MAX, no pix_valid. rast_done 2 cycles after
//   edge_done.
// - T4: all coefficients 0, bbox x 310..400, y 239..239 -> 10 pixels x=310..319, y=239.
// - T5: second edge_done while WALK in T1 -> overrun=1; T1 output unchanged.
//   A new edge_done after rast_done is accepted.
// - T6: assert rst_n=0 after the 5th pixel of T1 -> pix_valid=0 immediately, rast_ready=1,
//   no rast_done. A rerun of T1 gives 15 pixels.

Source files
------------

// File: rtl/tri_raster_walk_if.sv
// tri_raster_walk_if: triangle-setup input bundle and pixel output stream of the rasterizer
interface tri_raster_walk_if;
    logic               edge_done;
    logic signed [9:0]  a1, a2, a3;
    logic signed [9:0]  b1, b2, b3;
    logic signed [17:0] c1, c2, c3;
    logic [8:0]         bbxi, bbxf;
    logic [7:0]         bbyi, bbyf;
    logic               rast_ready;
    logic               pix_valid;
    logic               pix_ready;
    logic [8:0]         pix_x;
    logic [7:0]         pix_y;
    logic               rast_done;
    logic               overrun;

    modport slave (
        input  edge_done, a1, a2, a3, b1, b2, b3, c1, c2, c3, bbxi, bbxf, bbyi, bbyf, pix_ready,
        output rast_ready, pix_valid, pix_x, pix_y, rast_done, overrun
    );

    modport master (
        output edge_done, a1, a2, a3, b1, b2, b3, c1, c2, c3, bbxi, bbxf, bbyi, bbyf, pix_ready,
        input  rast_ready, pix_valid, pix_x, pix_y, rast_done, overrun
    );
endinterface

// File: rtl/tri_raster_walk.sv
// tri_raster_walk: walks a clipped triangle bbox row-major with incremental edge functions, streaming covered pixels
module tri_raster_walk #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239,
    parameter int EW    = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    tri_raster_walk_if.slave  io_bus
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WALK, S_DRAIN, S_DONE} state_t;

    state_t                r_state, w_next;
    logic signed [9:0]     r_a [3];
    logic signed [9:0]     r_b [3];
    logic signed [17:0]    r_c [3];
    logic signed [EW-1:0]  r_e [3];
    logic signed [EW-1:0]  r_r [3];
    logic [8:0]            r_x, r_xs, r_xe;
    logic [7:0]            r_y, r_ys, r_ye;
    logic                  r_pix_valid;
    logic [8:0]            r_pix_x;
    logic [7:0]            r_pix_y;
    logic                  r_rast_done;
    logic                  r_overrun;

    logic signed [9:0]     w_a_in [3];
    logic signed [9:0]     w_b_in [3];
    logic signed [17:0]    w_c_in [3];
    logic [8:0]            w_xe;
    logic [7:0]            w_ye;
    logic                  w_empty;
    logic                  w_adv;
    logic                  w_inside;
    logic                  w_x_last;
    logic                  w_y_last;

    // Full edge evaluation at the first candidate; everything after is incremental.
    function automatic logic signed [EW-1:0] f_eval(
        input logic signed [9:0]  a,
        input logic signed [9:0]  b,
        input logic signed [17:0] c,
        input logic [8:0]         x,
        input logic [7:0]         y
    );
        logic signed [EW-1:0] sa, sb, sc, sx, sy;
        sa = {{(EW-10){a[9]}}, a};
        sb = {{(EW-10){b[9]}}, b};
        sc = {{(EW-18){c[17]}}, c};
        sx = {{(EW-9){1'b0}}, x};
        sy = {{(EW-8){1'b0}}, y};
        return sa * sx + sb * sy + sc;
    endfunction

    assign w_a_in[0] = io_bus.a1;
    assign w_a_in[1] = io_bus.a2;
    assign w_a_in[2] = io_bus.a3;
    assign w_b_in[0] = io_bus.b1;
    assign w_b_in[1] = io_bus.b2;
    assign w_b_in[2] = io_bus.b3;
    assign w_c_in[0] = io_bus.c1;
    assign w_c_in[1] = io_bus.c2;
    assign w_c_in[2] = io_bus.c3;

    // Screen clip on the incoming box; an empty range skips straight to DONE.
    assign w_xe     = (io_bus.bbxf > 9'(X_MAX)) ? 9'(X_MAX) : io_bus.bbxf;
    assign w_ye     = (io_bus.bbyf > 8'(Y_MAX)) ? 8'(Y_MAX) : io_bus.bbyf;
    assign w_empty  = (io_bus.bbxi > w_xe) || (io_bus.bbyi > w_ye);

    // The output slot can take a new candidate result when empty or being drained.
    assign w_adv    = !r_pix_valid || io_bus.pix_ready;
    assign w_inside = !r_e[0][EW-1] && !r_e[1][EW-1] && !r_e[2][EW-1];
    assign w_x_last = r_x >= r_xe;
    assign w_y_last = r_y >= r_ye;

    assign io_bus.rast_ready = (r_state == S_IDLE);
    assign io_bus.pix_valid  = r_pix_valid;
    assign io_bus.pix_x      = r_pix_x;
    assign io_bus.pix_y      = r_pix_y;
    assign io_bus.rast_done  = r_rast_done;
    assign io_bus.overrun    = r_overrun;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: walk ends once the last candidate is evaluated, then waits for the slot to empty.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = io_bus.edge_done ? (w_empty ? S_DONE : S_SETUP) : S_IDLE;
            S_SETUP: w_next = S_WALK;
            S_WALK:  w_next = (w_adv && w_x_last && w_y_last) ? S_DRAIN : S_WALK;
            S_DRAIN: w_next = w_adv ? S_DONE : S_DRAIN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Coefficient latch, edge setup and the incremental row-major walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_c[k] <= '0;
                r_e[k] <= '0;
                r_r[k] <= '0;
            end
            r_x  <= '0;
            r_xs <= '0;
            r_xe <= '0;
            r_y  <= '0;
            r_ys <= '0;
            r_ye <= '0;
        end else begin
            if (r_state == S_IDLE && io_bus.edge_done) begin
                for (int k = 0; k < 3; k++) begin
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_c[k] <= w_c_in[k];
                end
                r_xs <= io_bus.bbxi;
                r_xe <= w_xe;
                r_ys <= io_bus.bbyi;
                r_ye <= w_ye;
            end
            if (r_state == S_SETUP) begin
                for (int k = 0; k < 3; k++) begin
                    r_e[k] <= f_eval(r_a[k], r_b[k], r_c[k], r_xs, r_ys);
                    r_r[k] <= f_eval(r_a[k], r_b[k], r_c[k], r_xs, r_ys);
                end
                r_x <= r_xs;
                r_y <= r_ys;
            end
            if (r_state == S_WALK && w_adv) begin
                if (!w_x_last) begin
                    r_x <= r_x + 9'd1;
                    for (int k = 0; k < 3; k++)
                        r_e[k] <= r_e[k] + {{(EW-10){r_a[k][9]}}, r_a[k]};
                end else if (!w_y_last) begin
                    r_x <= r_xs;
                    r_y <= r_y + 8'd1;
                    for (int k = 0; k < 3; k++) begin
                        r_r[k] <= r_r[k] + {{(EW-10){r_b[k][9]}}, r_b[k]};
                        r_e[k] <= r_r[k] + {{(EW-10){r_b[k][9]}}, r_b[k]};
                    end
                end
            end
        end
    end

    // Output slot: load a covered candidate, otherwise empty once accepted; hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
        end else if (r_state == S_WALK && w_adv) begin
            r_pix_valid <= w_inside;
            if (w_inside) begin
                r_pix_x <= r_x;
                r_pix_y <= r_y;
            end
        end else if (io_bus.pix_ready) begin
            r_pix_valid <= 1'b0;
        end
    end

    // Completion pulse follows the DONE state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rast_done <= 1'b0;
        else        r_rast_done <= (r_state == S_DONE);
    end

    // Sticky flag for a setup pulse that arrived while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     r_overrun <= 1'b0;
        else if (io_bus.edge_done && r_state != S_IDLE) r_overrun <= 1'b1;
    end

endmodule

// File: tb/tb_tri_raster_walk.sv
// tb_tri_raster_walk: scoreboard bench for the triangle raster walker
module tb_tri_raster_walk;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tri_raster_walk_if bus();

    tri_raster_walk dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   t_a[3], t_b[3], t_c[3];
    int   t_xi, t_xf, t_yi, t_yf;

    task automatic set_tri(input int a1, input int a2, input int a3,
                           input int b1, input int b2, input int b3,
                           input int c1, input int c2, input int c3,
                           input int xi, input int xf, input int yi, input int yf);
        t_a[0] = a1; t_a[1] = a2; t_a[2] = a3;
        t_b[0] = b1; t_b[1] = b2; t_b[2] = b3;
        t_c[0] = c1; t_c[1] = c2; t_c[2] = c3;
        t_xi = xi; t_xf = xf; t_yi = yi; t_yf = yf;
    endtask

    // Reference coverage: direct evaluation of every clipped candidate, row-major.
    task automatic model_push();
        int   xe, ye, e;
        bit   in;
        pix_t p;
        xe = (t_xf > 319) ? 319 : t_xf;
        ye = (t_yf > 239) ? 239 : t_yf;
        for (int y = t_yi; y <= ye; y++)
            for (int x = t_xi; x <= xe; x++) begin
                in = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    e = t_a[k] * x + t_b[k] * y + t_c[k];
                    if (e < 0) in = 1'b0;
                end
                if (in) begin
                    p.x = x;
                    p.y = y;
                    exp_q.push_back(p);
                end
            end
    endtask

    // Called at a negedge; pulses edge_done across one rising edge and returns at the next negedge.
    task automatic send_tri();
        model_push();
        bus.a1 = t_a[0][9:0]; bus.a2 = t_a[1][9:0]; bus.a3 = t_a[2][9:0];
        bus.b1 = t_b[0][9:0]; bus.b2 = t_b[1][9:0]; bus.b3 = t_b[2][9:0];
        bus.c1 = t_c[0][17:0]; bus.c2 = t_c[1][17:0]; bus.c3 = t_c[2][17:0];
        bus.bbxi = t_xi[8:0]; bus.bbxf = t_xf[8:0];
        bus.bbyi = t_yi[7:0]; bus.bbyf = t_yf[7:0];
        bus.edge_done = 1'b1;
        @(negedge clk);
        bus.edge_done = 1'b0;
    endtask

    // Drains the stream against the scoreboard; cyc 1 is the negedge right after edge_done is taken.
    task automatic collect(input string name, input int mode, input int abort_after, input int ov_cyc,
                           output int npix, output int first_cyc, output int done_cyc);
        bit   prev_v, prev_r, done;
        int   px, py;
        pix_t e;
        prev_v = 0; prev_r = 0; done = 0; px = 0; py = 0;
        npix = 0; first_cyc = 0; done_cyc = 0;
        for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
            if (prev_v && !prev_r) begin
                n_checks++;
                if (bus.pix_valid !== 1'b1 || bus.pix_x !== px[8:0] || bus.pix_y !== py[7:0]) begin
                    n_errors++;
                    $display("FAIL %s stall_hold cyc %0d: got v=%0b (%0d,%0d) want v=1 (%0d,%0d)",
                             name, cyc, bus.pix_valid, bus.pix_x, bus.pix_y, px, py);
                end
            end
            if (bus.pix_valid && first_cyc == 0) first_cyc = cyc;
            if (bus.rast_done) begin
                done = 1;
                done_cyc = cyc;
            end
            bus.edge_done = (cyc == ov_cyc);
            if (cyc == ov_cyc) begin
                bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
                bus.b1 = '0; bus.b2 = '0; bus.b3 = '0;
                bus.c1 = '0; bus.c2 = '0; bus.c3 = '0;
                bus.bbxi = 9'd100; bus.bbxf = 9'd110; bus.bbyi = 8'd50; bus.bbyf = 8'd52;
            end
            bus.pix_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (bus.pix_valid && bus.pix_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL %s extra_pixel: got (%0d,%0d) want none", name, bus.pix_x, bus.pix_y);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.pix_x !== e.x[8:0] || bus.pix_y !== e.y[7:0]) begin
                        n_errors++;
                        $display("FAIL %s pixel %0d: got (%0d,%0d) want (%0d,%0d)",
                                 name, npix, bus.pix_x, bus.pix_y, e.x, e.y);
                    end
                end
                npix++;
            end
            prev_v = bus.pix_valid; prev_r = bus.pix_ready; px = bus.pix_x; py = bus.pix_y;
            if (!done) @(negedge clk);
            if (abort_after > 0 && npix == abort_after) break;
        end
        bus.edge_done = 1'b0;
        if (abort_after == 0) begin
            n_checks++;
            if (!done) begin
                n_errors++;
                $display("FAIL %s timeout: got no rast_done want rast_done", name);
            end
        end
    endtask

    // Common end-of-triangle checks: count, empty scoreboard, single-cycle done pulse.
    task automatic finish_tri(input string name, input int npix, input int want);
        n_checks++;
        if (npix != want || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s count: got %0d (left %0d) want %0d", name, npix, exp_q.size(), want);
        end
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (bus.rast_done !== 1'b0 || bus.rast_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done_pulse: got done=%0b ready=%0b want done=0 ready=1",
                     name, bus.rast_done, bus.rast_ready);
        end
    endtask

    task automatic set_t1();
        set_tri(0, -4, 4, 4, -4, 0, 0, 16, 0, 0, 4, 0, 4);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.rast_ready !== 1'b1 || bus.pix_valid !== 1'b0 || bus.rast_done !== 1'b0 || bus.overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL reset flags: got rdy=%0b v=%0b done=%0b ovr=%0b want 1 0 0 0",
                     bus.rast_ready, bus.pix_valid, bus.rast_done, bus.overrun);
        end
        n_checks++;
        if (bus.pix_x !== 9'd0 || bus.pix_y !== 8'd0) begin
            n_errors++;
            $display("FAIL reset pix: got (%0d,%0d) want (0,0)", bus.pix_x, bus.pix_y);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n, f, d;
        set_t1();
        send_tri();
        n_checks++;
        if (bus.rast_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL t1 busy_ready: got %0b want 0", bus.rast_ready);
        end
        collect("t1", 0, 0, 0, n, f, d);
        n_checks++;
        if (f != 3) begin
            n_errors++;
            $display("FAIL t1 latency: got first valid at cyc %0d want 3", f);
        end
        finish_tri("t1", n, 15);
    endtask

    task automatic test_stall();
        int n, f, d;
        set_t1();
        send_tri();
        collect("t2", 1, 0, 0, n, f, d);
        finish_tri("t2", n, 15);
    endtask

    task automatic test_empty();
        int n, f, d;
        set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 400, 420, 0, 5);
        send_tri();
        collect("t3", 0, 0, 0, n, f, d);
        n_checks++;
        if (f != 0 || d != 2) begin
            n_errors++;
            $display("FAIL t3 empty: got first_valid=%0d done_cyc=%0d want 0 2", f, d);
        end
        finish_tri("t3", n, 0);
        set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 250, 255);
        send_tri();
        collect("t3y", 0, 0, 0, n, f, d);
        n_checks++;
        if (f != 0 || d != 2) begin
            n_errors++;
            $display("FAIL t3y empty: got first_valid=%0d done_cyc=%0d want 0 2", f, d);
        end
        finish_tri("t3y", n, 0);
    endtask

    task automatic test_clip();
        int n, f, d;
        set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 310, 400, 239, 239);
        send_tri();
        collect("t4", 0, 0, 0, n, f, d);
        finish_tri("t4", n, 10);
    endtask

    task automatic test_overrun();
        int n, f, d;
        set_t1();
        send_tri();
        collect("t5", 0, 0, 6, n, f, d);
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL t5 overrun: got %0b want 1", bus.overrun);
        end
        finish_tri("t5", n, 15);
        test_clip();
        n_checks++;
        if (bus.overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL t5 sticky: got %0b want 1", bus.overrun);
        end
    endtask

    task automatic test_reset_mid();
        int n, f, d;
        set_t1();
        send_tri();
        collect("t6", 0, 5, 0, n, f, d);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.pix_valid !== 1'b0 || bus.rast_ready !== 1'b1 || bus.rast_done !== 1'b0) begin
            n_errors++;
            $display("FAIL t6 async: got v=%0b rdy=%0b done=%0b want 0 1 0",
                     bus.pix_valid, bus.rast_ready, bus.rast_done);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.rast_done !== 1'b0 || bus.overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL t6 held: got done=%0b ovr=%0b want 0 0", bus.rast_done, bus.overrun);
        end
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.rast_done !== 1'b0 || bus.pix_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL t6 release: got done=%0b v=%0b want 0 0", bus.rast_done, bus.pix_valid);
        end
        test_basic();
    endtask

    initial begin
        bus.edge_done = 1'b0;
        bus.pix_ready = 1'b1;
        set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
        bus.b1 = '0; bus.b2 = '0; bus.b3 = '0;
        bus.c1 = '0; bus.c2 = '0; bus.c3 = '0;
        bus.bbxi = '0; bus.bbxf = '0; bus.bbyi = '0; bus.bbyf = '0;
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_clip();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
